ws2811_scheduler: RTL

WS2811_SCHEDULER -- requirements
Module: ws2811_scheduler

---
 rtl/ws2811_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/ws2811_scheduler.sv
// Pulls {EOF, repeat count, GRB} entries from a FIFO and streams each colour N times
// to a WS2811 serializer over a valid/ready link, then times the low-line latch gap.
module ws2811_scheduler #(
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [55:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [23:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        latch,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] LATCH = 3'd4;

    localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LCW-1:0] LATCH_LAST = (LATCH_CYCLES > 0) ? LCW'(LATCH_CYCLES - 1) : '0;

    logic [2:0]     state;
    logic [23:0]    colour;
    logic [15:0]    remaining;
    logic           eof;
    logic [LCW-1:0] latch_cnt;
    logic           fetch_ok;
    logic           unused_bits;

    assign unused_bits = ^fifo_dout[54:40];
    assign fetch_ok    = enable && !fifo_empty;

    // Handshake: a pixel moves on a rising edge where px_valid && px_ready. Once
    // px_valid is raised it stays high with px_data frozen until that edge.
    assign px_valid   = (state == SEND);
    assign px_data    = colour;
    assign latch      = (state == LATCH);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    // Gated by rst so a pop requested in the reset cycle never reaches the FIFO.
    assign fifo_rd_en = (state == FETCH) && !fifo_empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            colour     <= '0;
            remaining  <= '0;
            eof        <= 1'b0;
            latch_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_ok) state <= FETCH;
                end
                FETCH: begin
                    state <= fifo_empty ? IDLE : LOAD;
                end
                LOAD: begin
                    colour    <= fifo_dout[23:0];
                    remaining <= fifo_dout[39:24];
                    eof       <= fifo_dout[55];
                    if (fifo_dout[39:24] != 16'd0) state <= SEND;
                    else if (fifo_dout[55])        state <= LATCH;
                    else                           state <= IDLE;
                end
                SEND: begin
                    if (px_ready) begin
                        remaining <= remaining - 16'd1;
                        // Chaining straight into FETCH keeps inter-entry overhead at two cycles.
                        if (remaining == 16'd1) begin
                            if (eof)           state <= LATCH;
                            else if (fetch_ok) state <= FETCH;
                            else               state <= IDLE;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        latch_cnt  <= '0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
